// File: rtl/channel_collector_mux_pkg.sv
// channel_collector_mux_pkg
//   Shared types and constants for the 16-channel round-robin collector.
//   Holds the channel-number enum, the two-state FSM type, the default
//   hold timeout, the heartbeat divider constant and the field limits
//   of the addressed stream word.
package channel_collector_mux_pkg;

  localparam int N_CH   = 16;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int CH_W   = 4;

  // 10 ms at 50 MHz before a word the sink ignores is discarded.
  localparam int TIMEOUT_CYC  = 500_000;
  // Heartbeat LED half-period: 0.5 s at 50 MHz.
  localparam int ONE_CNT_OPER = 25_000_000;

  localparam int ADDR_MSB = ADDR_W - 1;
  localparam int ADDR_LSB = 0;
  localparam int DATA_MSB = DATA_W - 1;
  localparam int DATA_LSB = 0;

  typedef enum logic [CH_W-1:0] {
    CH_0,  CH_1,  CH_2,  CH_3,  CH_4,  CH_5,  CH_6,  CH_7,
    CH_8,  CH_9,  CH_10, CH_11, CH_12, CH_13, CH_14, CH_15
  } ch_num_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Channel after c, wrapping 15 -> 0.
  function automatic ch_num_t next_ch(input logic [CH_W-1:0] c);
    return ch_num_t'(c + 4'd1);
  endfunction

endpackage

// File: rtl/channel_collector_mux_rr_arbiter_16.sv
// rr_arbiter_16
//   Purely combinational 16-way round-robin arbiter. The search starts at
//   ptr and wraps 15 -> 0; the first requesting channel wins.
//   Ports:
//     req [15:0]  request vector
//     ptr [3:0]   highest-priority channel this cycle
//     gnt [15:0]  one-hot grant (all zero when no request)
//     idx [3:0]   encoded winner (0 when no request)
//     any         at least one request present
module rr_arbiter_16 (
  input  logic [15:0] req,
  input  logic [3:0]  ptr,
  output logic [15:0] gnt,
  output logic [3:0]  idx,
  output logic        any
);

  // Requests rotated so that bit 0 is the channel at ptr.
  logic [15:0] rot_req;
  logic [3:0]  offset;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rot
      logic [3:0] pos;
      assign pos         = ptr + 4'(gi);
      assign rot_req[gi] = req[pos];
    end
  endgenerate

  // Lowest set bit of the rotated vector; scanning from the top lets the
  // last assignment be the highest-priority match.
  always_comb begin
    offset = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rot_req[i]) offset = 4'(i);
    end
  end

  assign any = |req;
  assign idx = any ? (ptr + offset) : 4'd0;

  generate
    for (gi = 0; gi < 16; gi++) begin : g_gnt
      assign gnt[gi] = any && (idx == 4'(gi));
    end
  endgenerate

endmodule

// File: rtl/channel_collector_mux.sv
// channel_collector_mux
//   Collects 16-bit words from 16 channel sources with round-robin
//   arbitration and emits each as an addressed stream word (channel
//   number + data) over a valid/ready handshake. A word that the sink
//   does not take within TIMEOUT_CYC cycles is dropped and counted.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     ch_valid [15:0]     per-channel word available
//     ch_data  [255:0]    channel k at [16k+15:16k]
//     ch_ready [15:0]     one-hot accept strobe (IDLE only, combinational)
//     out_valid/out_addr/out_data/out_ready   stream handshake
//     drop_pulse          one cycle after a timeout drop
//     drop_cnt [7:0]      saturating drop counter
//     led [4:0]           only with MUX_HEARTBEAT_EN: led[0] heartbeat,
//                         led[4:1] channel of the last completed transfer
//   Optional feature macro: MUX_HEARTBEAT_EN
module channel_collector_mux #(
  parameter int TIMEOUT_CYC = channel_collector_mux_pkg::TIMEOUT_CYC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  ch_valid,
  input  logic [255:0] ch_data,
  output logic [15:0]  ch_ready,
  output logic         out_valid,
  output logic [7:0]   out_addr,
  output logic [15:0]  out_data,
  input  logic         out_ready,
  output logic         drop_pulse,
  output logic [7:0]   drop_cnt
`ifdef MUX_HEARTBEAT_EN
  ,
  output logic [4:0]   led
`endif
);

  import channel_collector_mux_pkg::*;

  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);

  state_t              state_reg, state_next;
  ch_num_t             ptr_reg, ptr_next;
  logic [ADDR_MSB:0]   addr_reg, addr_next;
  logic [DATA_MSB:0]   data_reg, data_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic                drop_pulse_reg, drop_pulse_next;
  logic [7:0]          drop_cnt_reg, drop_cnt_next;

  logic [15:0]         arb_gnt;
  logic [3:0]          arb_idx;
  logic                arb_any;
  logic [DATA_MSB:0]   sel_data;

  rr_arbiter_16 u_arb (
    .req (ch_valid),
    .ptr (ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign sel_data = ch_data[{arb_idx, 4'b0000} +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= CH_0;
      addr_reg       <= '0;
      data_reg       <= '0;
      timer_reg      <= '0;
      drop_pulse_reg <= 1'b0;
      drop_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      timer_reg      <= timer_next;
      drop_pulse_reg <= drop_pulse_next;
      drop_cnt_reg   <= drop_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    addr_next       = addr_reg;
    data_next       = data_reg;
    timer_next      = timer_reg;
    drop_pulse_next = 1'b0;
    drop_cnt_next   = drop_cnt_reg;
    ch_ready        = '0;

    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          ch_ready   = arb_gnt;
          data_next  = sel_data;
          addr_next  = {4'b0000, arb_idx};
          timer_next = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        // A transfer in the timeout cycle takes precedence over the drop.
        if (out_ready) begin
          ptr_next   = next_ch(addr_reg[3:0]);
          state_next = IDLE;
        end else if (timer_reg == TIMER_W'(TIMEOUT_CYC - 1)) begin
          ptr_next        = next_ch(addr_reg[3:0]);
          drop_pulse_next = 1'b1;
          if (drop_cnt_reg != 8'hFF) drop_cnt_next = drop_cnt_reg + 8'd1;
          state_next      = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_valid  = (state_reg == SEND);
  assign out_addr   = addr_reg;
  assign out_data   = data_reg;
  assign drop_pulse = drop_pulse_reg;
  assign drop_cnt   = drop_cnt_reg;

`ifdef MUX_HEARTBEAT_EN
  localparam int HB_W = $clog2(ONE_CNT_OPER);

  logic [HB_W-1:0] hb_cnt_reg;
  logic            hb_led_reg;
  logic [3:0]      last_ch_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt_reg  <= '0;
      hb_led_reg  <= 1'b0;
      last_ch_reg <= '0;
    end else begin
      if (hb_cnt_reg == HB_W'(ONE_CNT_OPER - 1)) begin
        hb_cnt_reg <= '0;
        hb_led_reg <= ~hb_led_reg;
      end else begin
        hb_cnt_reg <= hb_cnt_reg + 1'b1;
      end
      if (state_reg == SEND && out_ready) last_ch_reg <= addr_reg[3:0];
    end
  end

  assign led = {last_ch_reg, hb_led_reg};
`endif

endmodule

// File: tb/tb_channel_collector_mux.sv
// tb_channel_collector_mux
//   Directed and randomized checks of channel_collector_mux with a short
//   timeout. The reference model tracks "a word is held / not held",
//   the round-robin start channel and the drop count, and predicts the
//   outputs for every cycle.
module tb_channel_collector_mux;

  localparam int T = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  ch_valid;
  logic [255:0] ch_data;
  logic [15:0]  ch_ready;
  logic         out_valid;
  logic [7:0]   out_addr;
  logic [15:0]  out_data;
  logic         out_ready;
  logic         drop_pulse;
  logic [7:0]   drop_cnt;
`ifdef MUX_HEARTBEAT_EN
  logic [4:0]   led;
`endif

  channel_collector_mux #(.TIMEOUT_CYC(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
`ifdef MUX_HEARTBEAT_EN
    ,
    .led        (led)
`endif
  );

  always #10 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  // Reference model state.
  int          m_ptr  = 0;
  bit          m_busy = 0;
  int          m_addr = 0;
  logic [15:0] m_data = '0;
  int          m_wait = 0;
  bit          m_drop = 0;
  int          m_cnt  = 0;

  // First valid channel starting at m_ptr, wrapping; -1 if none.
  function automatic int m_grant(input logic [15:0] v);
    for (int k = 0; k < 16; k++) begin
      int c;
      c = (m_ptr + k) % 16;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] m_ready();
    int g;
    g = m_grant(ch_valid);
    if (!m_busy && g >= 0) return 16'(1) << g;
    return 16'h0000;
  endfunction

  // Advance the model with the inputs present before the edge, then clock.
  task automatic clock_edge();
    int g;
    g = m_grant(ch_valid);
    if (rst) begin
      m_ptr = 0; m_busy = 0; m_addr = 0; m_data = '0;
      m_wait = 0; m_drop = 0; m_cnt = 0;
    end else begin
      m_drop = 0;
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1;
          m_addr = g;
          m_data = ch_data[g*16 +: 16];
          m_wait = 0;
        end
      end else if (out_ready) begin
        m_busy = 0;
        m_ptr  = (m_addr + 1) % 16;
      end else if (m_wait == T - 1) begin
        m_busy = 0;
        m_drop = 1;
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_ptr  = (m_addr + 1) % 16;
      end else begin
        m_wait++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 8; i++) ch_data[i*32 +: 32] = $urandom;
  endtask

  task automatic apply_reset();
    rst = 1'b1; ch_valid = '0; out_ready = 1'b0;
    clock_edge();
    clock_edge();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      #1;
      tests_run++;
      if ({out_valid, ch_ready, drop_cnt, drop_pulse, out_addr, out_data} !== '0) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: got valid=%b ready=%h cnt=%0d pulse=%b addr=%h data=%h, expected all zero",
                 c, out_valid, ch_ready, drop_cnt, drop_pulse, out_addr, out_data);
      end
      clock_edge();
    end
  endtask

  task automatic test_single();
    $display("[TB] test_single");
    apply_reset();
    randomize_data();
    ch_data[3*16 +: 16] = 16'hA5A5;
    ch_valid = 16'h0008; out_ready = 1'b1;
    #1;
    tests_run++;
    if (ch_ready !== 16'h0008) begin
      fails++; $display("FAIL single_ready: got %h expected 0008", ch_ready);
    end
    clock_edge();
    ch_valid = '0;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_addr !== 8'h03 || out_data !== 16'hA5A5 || ch_ready !== 16'h0) begin
      fails++;
      $display("FAIL single_word: got valid=%b addr=%h data=%h ready=%h expected 1/03/a5a5/0000",
               out_valid, out_addr, out_data, ch_ready);
    end
    clock_edge();
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL single_done: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_all_valid();
    int nxfer;
    $display("[TB] test_all_valid");
    apply_reset();
    nxfer = 0;
    ch_valid = 16'hFFFF; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      randomize_data();
      #1;
      tests_run++;
      if (ch_ready !== m_ready()) begin
        fails++; $display("FAIL all_ready cyc %0d: got %h expected %h", c, ch_ready, m_ready());
      end
      if (out_valid) begin
        tests_run++;
        if (out_addr !== 8'(nxfer % 16) || out_data !== m_data) begin
          fails++;
          $display("FAIL all_seq word %0d: got addr=%h data=%h expected addr=%h data=%h",
                   nxfer, out_addr, out_data, 8'(nxfer % 16), m_data);
        end
        $display("[TB] xfer %0d addr=%h data=%h", nxfer, out_addr, out_data);
        nxfer++;
      end
      clock_edge();
    end
    tests_run++;
    if (nxfer != 20) begin
      fails++; $display("FAIL all_count: got %0d words expected 20", nxfer);
    end
    ch_valid = '0;
  endtask

  task automatic test_wrap();
    $display("[TB] test_wrap");
    apply_reset();
    randomize_data();
    out_ready = 1'b1;
    ch_valid = 16'h4000;
    #1;
    tests_run++;
    if (ch_ready !== 16'h4000) begin
      fails++; $display("FAIL wrap_g14: got %h expected 4000", ch_ready);
    end
    clock_edge();
    ch_valid = 16'h8001;
    #1;
    tests_run++;
    if (out_addr !== 8'd14 || out_valid !== 1'b1 || ch_ready !== 16'h0) begin
      fails++; $display("FAIL wrap_w14: got addr=%h valid=%b ready=%h expected 0e/1/0000", out_addr, out_valid, ch_ready);
    end
    clock_edge();
    #1;
    tests_run++;
    if (ch_ready !== 16'h8000) begin
      fails++; $display("FAIL wrap_g15: got %h expected 8000", ch_ready);
    end
    clock_edge();
    #1;
    tests_run++;
    if (out_addr !== 8'd15) begin
      fails++; $display("FAIL wrap_w15: got %h expected 0f", out_addr);
    end
    clock_edge();
    #1;
    tests_run++;
    if (ch_ready !== 16'h0001) begin
      fails++; $display("FAIL wrap_g0: got %h expected 0001", ch_ready);
    end
    clock_edge();
    #1;
    tests_run++;
    if (out_addr !== 8'd0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL wrap_w0: got addr=%h valid=%b expected 00/1", out_addr, out_valid);
    end
    ch_valid = '0;
    clock_edge();
  endtask

  task automatic test_timeout();
    $display("[TB] test_timeout");
    apply_reset();
    randomize_data();
    ch_valid = 16'h0080; out_ready = 1'b0;
    #1;
    tests_run++;
    if (ch_ready !== 16'h0080) begin
      fails++; $display("FAIL to_grant: got %h expected 0080", ch_ready);
    end
    clock_edge();
    ch_valid = '0;
    for (int i = 0; i < T; i++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || drop_pulse !== 1'b0) begin
        fails++; $display("FAIL to_hold cyc %0d: got valid=%b pulse=%b expected 1/0", i, out_valid, drop_pulse);
      end
      clock_edge();
    end
    ch_valid = 16'hFFFF;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || drop_pulse !== 1'b1 || drop_cnt !== 8'd1 || ch_ready !== 16'h0100) begin
      fails++;
      $display("FAIL to_drop: got valid=%b pulse=%b cnt=%0d ready=%h expected 0/1/1/0100",
               out_valid, drop_pulse, drop_cnt, ch_ready);
    end
    clock_edge();
    ch_valid = '0; out_ready = 1'b1;
    #1;
    tests_run++;
    if (drop_pulse !== 1'b0 || out_addr !== 8'd8 || drop_cnt !== 8'd1) begin
      fails++; $display("FAIL to_after: got pulse=%b addr=%h cnt=%0d expected 0/08/1", drop_pulse, out_addr, drop_cnt);
    end
    clock_edge();
  endtask

  task automatic test_timeout_race();
    $display("[TB] test_timeout_race");
    apply_reset();
    randomize_data();
    ch_valid = 16'h0004; out_ready = 1'b0;
    clock_edge();
    ch_valid = '0;
    for (int i = 0; i < T - 1; i++) clock_edge();
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL race_hold: got valid=%b expected 1", out_valid);
    end
    clock_edge();
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || drop_pulse !== 1'b0 || drop_cnt !== 8'd0) begin
      fails++; $display("FAIL race_xfer: got valid=%b pulse=%b cnt=%0d expected 0/0/0", out_valid, drop_pulse, drop_cnt);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    $display("[TB] test_reset_mid_send");
    apply_reset();
    randomize_data();
    ch_valid = 16'h0020; out_ready = 1'b0;
    clock_edge();
    ch_valid = '0;
    clock_edge();
    clock_edge();
    #1;
    tests_run++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL rms_hold: got valid=%b expected 1", out_valid);
    end
    rst = 1'b1;
    clock_edge();
    rst = 1'b0;
    for (int c = 0; c < T + 3; c++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || drop_pulse !== 1'b0 || drop_cnt !== 8'd0) begin
        fails++;
        $display("FAIL rms_after cyc %0d: got valid=%b pulse=%b cnt=%0d expected 0/0/0", c, out_valid, drop_pulse, drop_cnt);
      end
      clock_edge();
    end
  endtask

  task automatic test_random();
    int slow;
    $display("[TB] test_random");
    apply_reset();
    slow = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) slow = $urandom_range(0, 3);
      randomize_data();
      ch_valid  = 16'($urandom) & 16'($urandom) & 16'($urandom);
      out_ready = (slow == 0) ? 1'b0 : ($urandom_range(0, slow) != 0);
      rst       = ($urandom_range(0, 499) == 0);
      #1;
      tests_run++;
      if (ch_ready !== m_ready() || out_valid !== m_busy || out_addr !== 8'(m_addr) ||
          out_data !== m_data || drop_pulse !== m_drop || drop_cnt !== 8'(m_cnt)) begin
        fails++;
        $display("FAIL random cyc %0d: got ready=%h valid=%b addr=%h data=%h pulse=%b cnt=%0d expected ready=%h valid=%b addr=%h data=%h pulse=%b cnt=%0d",
                 c, ch_ready, out_valid, out_addr, out_data, drop_pulse, drop_cnt,
                 m_ready(), m_busy, 8'(m_addr), m_data, m_drop, m_cnt);
      end
      clock_edge();
    end
    rst = 1'b0;
  endtask

  task automatic test_saturate();
    $display("[TB] test_saturate");
    apply_reset();
    ch_valid = 16'hFFFF; out_ready = 1'b0;
    for (int c = 0; c < 260 * (T + 1) + 4; c++) begin
      #1;
      tests_run++;
      if (drop_cnt !== 8'(m_cnt) || drop_pulse !== m_drop) begin
        fails++;
        $display("FAIL sat cyc %0d: got cnt=%0d pulse=%b expected cnt=%0d pulse=%b", c, drop_cnt, drop_pulse, m_cnt, m_drop);
      end
      clock_edge();
    end
    #1;
    tests_run++;
    if (drop_cnt !== 8'd255) begin
      fails++; $display("FAIL sat_final: got %0d expected 255", drop_cnt);
    end
    ch_valid = '0;
  endtask

  initial begin
    rst = 1'b1; ch_valid = '0; ch_data = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_all_valid();
    test_wrap();
    test_timeout();
    test_timeout_race();
    test_reset_mid_send();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/channel_collector_mux.md
Name: channel_collector_mux

Overview:
- Reverse direction of the 16-channel demultiplexer.
- Collects 16-bit words from 16 per-channel sources using round-robin arbitration.
- Emits each word as one addressed stream word (8-bit address, 16-bit data) with valid/ready handshake toward the shared bus.
- Out-of-range hold protection: a word held too long by the sink is dropped and counted.

Parameters:
- N_CH, 16, number of channel inputs (fixed at 16, matching the channel-number type).
- DATA_W, 16, channel/stream data width.
- ADDR_W, 8, stream address width.
- TIMEOUT_CYC, 500_000, max cycles a word waits for out_ready before drop (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz nominal
- rst  in  1  synchronous active-high reset
- ch_valid  in  16  per-channel word available
- ch_data  in  256  flattened channel data; channel k at [16k+15:16k]
- ch_ready  out  16  one-hot accept strobe per channel
- out_valid  out  1  stream word valid
- out_addr  out  8  channel number of current word, zero-extended
- out_data  out  16  stream data
- out_ready  in  1  sink accepts
- drop_pulse  out  1  one-cycle pulse when a word is dropped on timeout
- drop_cnt  out  8  saturating count of dropped words

Behaviour:
- Reset values: state IDLE, ptr=0, out_valid=0, out_addr=0, out_data=0, ch_ready=0, drop_pulse=0, drop_cnt=0, timer=0.
- Reset is synchronous. Reset mid-SEND discards the held word with no drop_pulse and no drop_cnt change.
- FSM states: IDLE, SEND.
- IDLE, no ch_valid: ch_ready=0.
- IDLE, any ch_valid:
  - Grant g = first valid channel scanning ptr, ptr+1 … wrapping 15→0.
  - ch_ready = one-hot(g), combinational from ch_valid and ptr, IDLE only.
  - Same cycle: register out_data=ch_data[g], out_addr=g, timer=0; go SEND.
- SEND: out_valid=1; out_addr and out_data held stable; ch_ready=0.
  - out_ready=1: transfer completes; ptr=(g+1) mod 16; go IDLE.
  - out_ready=0: timer+1.
  - out_ready=0 and timer==TIMEOUT_CYC-1: drop. Next cycle out_valid=0, drop_pulse=1, drop_cnt+1 (saturates at 255), ptr=(g+1) mod 16, state IDLE.
  - out_ready=1 in the same cycle the timeout is reached: transfer wins; no drop.
- Latency: channel accepted in cycle N → out_valid in cycle N+1.
- Throughput: max one word per 2 cycles (IDLE/SEND alternation).
- Fairness: every continuously-valid channel is served within 16 grants.
- ch_valid dropping while not granted: no effect; no data sampled.
- out_data/out_addr are don't-care-stable while out_valid=0 (hold last value).

Optional Feature:
- MUX_HEARTBEAT_EN defined:
  - Adds output led, 5 bits.
  - led[0] toggles every ONE_CNT_OPER cycles via a free-running counter; reset 0.
  - led[4:1] = channel number of the last completed transfer; reset 0.
- MUX_HEARTBEAT_EN undefined: no led port, no counter logic.

Decomposition:
- Shared package holds:
  - channel number enum (16 points, values 0–15)
  - FSM state typedef {IDLE, SEND}
  - TIMEOUT_CYC and ONE_CNT_OPER constants
  - address/data MSB/LSB constants
- Sub-module rr_arbiter_16:
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: one-hot gnt[15:0], encoded idx[3:0], any.
  - Purely combinational.

Test Plan:
- Reset then ch_valid=0 for 20 cycles → out_valid=0, ch_ready=0, drop_cnt=0.
- ch_valid[3]=1, ch_data[3]=16'hA5A5, out_ready=1 → ch_ready[3] in cycle N; out_valid, out_addr=8'h03, out_data=16'hA5A5 in cycle N+1.
- All 16 channels valid continuously, out_ready=1 → out_addr sequence 0,1,…,15,0; each channel granted once per 16 words.
- ch_valid[15] only, then ch_valid[0] with ptr at 15 → grant 15 then 0 (wrap).
- Word on channel 7, out_ready=0 for TIMEOUT_CYC cycles → one drop_pulse, drop_cnt=1, out_valid falls, next grant starts at channel 8.
- out_ready rises exactly on cycle TIMEOUT_CYC-1 → word transferred, no drop_pulse. Separately, rst asserted mid-SEND → out_valid=0 next cycle, drop_cnt unchanged.
